// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// State encoding, parity selector values and the prescale floor live here.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [4:0] MIN_PRESCALE = 5'd5;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Captures RX_IN three times around the middle of each bit and majority-votes
// the captures, so a single noisy cycle near mid-bit cannot flip the result.
module uart_rx_data_sampler (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       RX_IN,
  input  logic [4:0] edge_count,
  input  logic [4:0] Prescale,
  output logic       sampled_bit
);

  logic [4:0] mid;
  logic [2:0] samples_q;
  logic [2:0] samples_d;

  assign mid = Prescale >> 1;

  always_comb begin
    samples_d = samples_q;
    if (edge_count == mid - 5'd1) samples_d[0] = RX_IN;
    if (edge_count == mid)        samples_d[1] = RX_IN;
    if (edge_count == mid + 5'd1) samples_d[2] = RX_IN;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      samples_q <= 3'b000;
    end else begin
      samples_q <= samples_d;
    end
  end

  assign sampled_bit = (samples_q[0] & samples_q[1]) |
                       (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame FSM: detects the start bit, shifts data in LSB first,
// checks optional parity and the stop bit, and pulses Data_Valid on a good frame.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [4:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [4:0]            edge_count,
  input  logic [3:0]            bit_count,
  input  logic                  Last_edge,
  output logic                  count_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic [4:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  sampled_bit;
  logic                  par_expected;

  uart_rx_data_sampler u_sampler (
    .CLK         (CLK),
    .Reset       (Reset),
    .RX_IN       (RX_IN),
    .edge_count  (edge_count),
    .Prescale    (prescale_q),
    .sampled_bit (sampled_bit)
  );

  assign par_expected = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  // Every bit decision waits for Last_edge so the majority vote has settled.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    serr_d     = serr_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          perr_d     = 1'b0;
          serr_d     = 1'b0;
        end
      end
      START: begin
        if (Last_edge) state_d = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (Last_edge) begin
          shift_d = (shift_q >> 1) | (DATA_WIDTH'(sampled_bit) << (DATA_WIDTH - 1));
          if (bit_count == LAST_DATA_BIT) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (Last_edge) begin
          if (sampled_bit != par_expected) perr_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (Last_edge) begin
          if (!sampled_bit) begin
            serr_d = 1'b1;
          end else if (!perr_q) begin
            pdata_d = shift_q;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      pdata_q    <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      prescale_q <= MIN_PRESCALE;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
    end
  end

  assign count_EN     = (state_q != IDLE);
  assign P_DATA       = pdata_q;
  assign Data_Valid   = valid_q;
  assign Parity_Error = perr_q;
  assign Stop_Error   = serr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: emulates the neighbouring edge/bit counter,
// serialises frames onto RX_IN and compares against a frame-level model.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          RX_IN;
  logic [4:0]    Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [4:0]    edge_count;
  logic [3:0]    bit_count;
  logic          Last_edge;
  logic          count_EN;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Parity_Error;
  logic          Stop_Error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_count = 0;
  int last_dv_cycle = -1;
  logic [DW-1:0] dv_q[$];
  logic [DW-1:0] exp_pdata;

  logic [4:0] ec_q;
  logic [3:0] bc_q;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .edge_count   (edge_count),
    .bit_count    (bit_count),
    .Last_edge    (Last_edge),
    .count_EN     (count_EN),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stand-in for the edge counter: edge 1 on the first enabled cycle, wraps at Prescale.
  always @(posedge CLK or posedge Reset) begin
    if (Reset || !count_EN) begin
      ec_q <= 5'd1;
      bc_q <= 4'd0;
    end else if (ec_q == Prescale) begin
      ec_q <= 5'd1;
      bc_q <= bc_q + 4'd1;
    end else begin
      ec_q <= ec_q + 5'd1;
    end
  end

  assign edge_count = ec_q;
  assign bit_count  = bc_q;
  assign Last_edge  = count_EN && (ec_q == Prescale);

  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_count      <= dv_count + 1;
      last_dv_cycle <= cyc;
      dv_q.push_back(P_DATA);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference view of a frame: correct parity means the count of ones
  // (data plus parity bit) is even for even parity and odd for odd parity.
  function automatic logic parity_ok(input logic [DW-1:0] data, input logic ptyp,
                                     input logic pbit);
    int ones;
    ones = $countones(data) + int'(pbit);
    return (ptyp == PAR_ODD) ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic good_parity_bit(input logic [DW-1:0] data, input logic ptyp);
    int ones;
    ones = $countones(data);
    return ((ones % 2) == 1) ^ (ptyp == PAR_ODD);
  endfunction

  task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic [4:0] p,
                            input int flip_bit, input int gap, output int start_cyc);
    logic [DW+2:0] fbits;
    int nb;
    Prescale = p;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    fbits    = '0;
    fbits[0] = 1'b0;
    for (int i = 0; i < DW; i++) fbits[i+1] = data[i];
    nb = DW + 1;
    if (pen) begin
      fbits[nb] = pbit;
      nb++;
    end
    fbits[nb] = sbit;
    nb++;
    start_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int o = 0; o < int'(p); o++) begin
        RX_IN = (b == flip_bit && o == int'(p >> 1)) ? ~fbits[b] : fbits[b];
        tick();
      end
    end
    RX_IN = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    RX_IN    = 1'b1;
    Prescale = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    exp_pdata = '0;
    repeat (2) tick();
    checks++;
    if (count_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_count_en: got %b expected 0", count_EN);
    end
    checks++;
    if (P_DATA !== '0) begin
      errors++; $display("[TB] FAIL reset_p_data: got %h expected 00", P_DATA);
    end
    checks++;
    if ({Data_Valid, Parity_Error, Stop_Error} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b%b%b expected 000", Data_Valid, Parity_Error, Stop_Error);
    end
    Reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (count_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_count_en: got %b expected 0", count_EN);
    end
  endtask

  task automatic test_good_no_parity();
    int st, n0;
    n0 = dv_count;
    send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd8, -1, 3, st);
    tick();
    exp_pdata = 8'hA5;
    checks++;
    if (dv_count - n0 !== 1) begin
      errors++; $display("[TB] FAIL nopar_pulses: got %0d expected 1", dv_count - n0);
    end
    checks++;
    if (P_DATA !== exp_pdata) begin
      errors++; $display("[TB] FAIL nopar_data: got %h expected %h", P_DATA, exp_pdata);
    end
    checks++;
    if ({Parity_Error, Stop_Error} !== 2'b00) begin
      errors++; $display("[TB] FAIL nopar_flags: got %b%b expected 00", Parity_Error, Stop_Error);
    end
    checks++;
    if (last_dv_cycle - st !== 81) begin
      errors++; $display("[TB] FAIL nopar_latency: got %0d expected 81", last_dv_cycle - st);
    end
  endtask

  task automatic test_good_parity();
    int st, n0;
    logic ptyp;
    for (int i = 0; i < 2; i++) begin
      ptyp = (i == 1) ? PAR_ODD : PAR_EVEN;
      n0 = dv_count;
      exp_pdata = 8'h00;
      send_frame(8'hA5, 1'b1, ptyp, ptyp, 1'b1, 5'd8, -1, 3, st);
      tick();
      exp_pdata = 8'hA5;
      checks++;
      if (dv_count - n0 !== 1 || P_DATA !== exp_pdata) begin
        errors++;
        $display("[TB] FAIL par%0d_data: got %0d pulses data %h expected 1 pulse data %h",
                 i, dv_count - n0, P_DATA, exp_pdata);
      end
      checks++;
      if (Parity_Error !== 1'b0) begin
        errors++; $display("[TB] FAIL par%0d_perr: got %b expected 0", i, Parity_Error);
      end
      checks++;
      if (last_dv_cycle - st !== 89) begin
        errors++; $display("[TB] FAIL par%0d_latency: got %0d expected 89", i, last_dv_cycle - st);
      end
    end
  endtask

  task automatic test_parity_error();
    int st, n0;
    n0 = dv_count;
    send_frame(8'h01, 1'b1, PAR_EVEN, 1'b0, 1'b1, 5'd8, -1, 3, st);
    tick();
    checks++;
    if (dv_count - n0 !== 0) begin
      errors++; $display("[TB] FAIL perr_pulses: got %0d expected 0", dv_count - n0);
    end
    checks++;
    if (P_DATA !== exp_pdata) begin
      errors++; $display("[TB] FAIL perr_data_kept: got %h expected %h", P_DATA, exp_pdata);
    end
    checks++;
    if ({Parity_Error, Stop_Error} !== 2'b10) begin
      errors++; $display("[TB] FAIL perr_flags: got %b%b expected 10", Parity_Error, Stop_Error);
    end
  endtask

  task automatic test_stop_error_and_glitch();
    int st, n0;
    n0 = dv_count;
    send_frame(8'h77, 1'b0, PAR_EVEN, 1'b0, 1'b0, 5'd8, -1, 3, st);
    tick();
    checks++;
    if (dv_count - n0 !== 0 || P_DATA !== exp_pdata) begin
      errors++;
      $display("[TB] FAIL serr_no_valid: got %0d pulses data %h expected 0 pulses data %h",
               dv_count - n0, P_DATA, exp_pdata);
    end
    checks++;
    if ({Parity_Error, Stop_Error} !== 2'b01) begin
      errors++; $display("[TB] FAIL serr_flags: got %b%b expected 01", Parity_Error, Stop_Error);
    end
    checks++;
    if (count_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL serr_idle: got count_EN %b expected 0", count_EN);
    end
    n0 = dv_count;
    RX_IN = 1'b0;
    repeat (2) tick();
    RX_IN = 1'b1;
    checks++;
    if (count_EN !== 1'b1) begin
      errors++; $display("[TB] FAIL glitch_start: got count_EN %b expected 1", count_EN);
    end
    repeat (12) tick();
    checks++;
    if (count_EN !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_abort: got count_EN %b expected 0", count_EN);
    end
    checks++;
    if ({Parity_Error, Stop_Error} !== 2'b00 || dv_count - n0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_flags: got %b%b pulses %0d expected 00 pulses 0",
               Parity_Error, Stop_Error, dv_count - n0);
    end
  endtask

  task automatic test_noise_and_prescale5();
    int st, n0;
    n0 = dv_count;
    send_frame(8'hC3, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd8, 3, 3, st);
    tick();
    exp_pdata = 8'hC3;
    checks++;
    if (dv_count - n0 !== 1 || P_DATA !== exp_pdata) begin
      errors++;
      $display("[TB] FAIL noise_vote: got %0d pulses data %h expected 1 pulse data %h",
               dv_count - n0, P_DATA, exp_pdata);
    end
    n0 = dv_count;
    send_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd5, -1, 3, st);
    tick();
    exp_pdata = 8'h3C;
    checks++;
    if (dv_count - n0 !== 1 || P_DATA !== exp_pdata) begin
      errors++;
      $display("[TB] FAIL presc5_data: got %0d pulses data %h expected 1 pulse data %h",
               dv_count - n0, P_DATA, exp_pdata);
    end
    checks++;
    if (last_dv_cycle - st !== (DW + 2) * 5 + 1) begin
      errors++;
      $display("[TB] FAIL presc5_latency: got %0d expected %0d", last_dv_cycle - st, (DW + 2) * 5 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int st, n0;
    n0 = dv_count;
    send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd8, -1, 1, st);
    send_frame(8'h34, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd8, -1, 3, st);
    tick();
    exp_pdata = 8'h34;
    checks++;
    if (dv_count - n0 !== 2) begin
      errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", dv_count - n0);
    end else begin
      checks++;
      if (dv_q[dv_q.size()-2] !== 8'h12 || dv_q[dv_q.size()-1] !== 8'h34) begin
        errors++;
        $display("[TB] FAIL b2b_order: got %h,%h expected 12,34",
                 dv_q[dv_q.size()-2], dv_q[dv_q.size()-1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int st, n0;
    logic [DW-1:0] d;
    d = 8'hA5;
    Prescale = 5'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) tick();
    for (int b = 0; b < 3; b++) begin
      RX_IN = d[b];
      repeat (8) tick();
    end
    RX_IN = d[3];
    repeat (4) tick();
    checks++;
    if (count_EN !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_active: got count_EN %b expected 1", count_EN);
    end
    Reset = 1'b1;
    #1;
    exp_pdata = '0;
    checks++;
    if (P_DATA !== exp_pdata || count_EN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_clear: got data %h count_EN %b expected 00 0", P_DATA, count_EN);
    end
    checks++;
    if ({Data_Valid, Parity_Error, Stop_Error} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_mid_flags: got %b%b%b expected 000", Data_Valid, Parity_Error, Stop_Error);
    end
    tick();
    tick();
    Reset = 1'b0;
    RX_IN = 1'b1;
    repeat (2) tick();
    n0 = dv_count;
    send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 5'd8, -1, 3, st);
    tick();
    exp_pdata = 8'h5A;
    checks++;
    if (dv_count - n0 !== 1 || P_DATA !== exp_pdata) begin
      errors++;
      $display("[TB] FAIL rst_mid_recover: got %0d pulses data %h expected 1 pulse data %h",
               dv_count - n0, P_DATA, exp_pdata);
    end
  endtask

  task automatic test_random();
    int st, n0, kind, flip, gap, exp_pulses, exp_lat;
    logic [DW-1:0] data;
    logic [4:0] p;
    logic pen, ptyp, pbit, sbit, exp_perr, exp_serr;
    for (int n = 0; n < 24; n++) begin
      data = DW'($urandom);
      p    = 5'($urandom_range(int'(MIN_PRESCALE), 20));
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(2, 5);
      pbit = good_parity_bit(data, ptyp);
      sbit = 1'b1;
      flip = -1;
      if (kind == 0 && pen) pbit = ~pbit;
      if (kind == 1 || (kind == 0 && !pen)) sbit = 1'b0;
      if (kind == 2 || kind == 3) flip = $urandom_range(1, DW);
      exp_perr   = pen && !parity_ok(data, ptyp, pbit);
      exp_serr   = !sbit;
      exp_pulses = (!exp_perr && !exp_serr) ? 1 : 0;
      exp_lat    = (DW + 2 + int'(pen)) * int'(p) + 1;
      n0 = dv_count;
      send_frame(data, pen, ptyp, pbit, sbit, p, flip, gap, st);
      tick();
      if (exp_pulses == 1) exp_pdata = data;
      checks++;
      if (dv_count - n0 !== exp_pulses || P_DATA !== exp_pdata) begin
        errors++;
        $display("[TB] FAIL rand%0d_data: got %0d pulses data %h expected %0d pulses data %h",
                 n, dv_count - n0, P_DATA, exp_pulses, exp_pdata);
      end
      checks++;
      if ({Parity_Error, Stop_Error} !== {exp_perr, exp_serr}) begin
        errors++;
        $display("[TB] FAIL rand%0d_flags: got %b%b expected %b%b",
                 n, Parity_Error, Stop_Error, exp_perr, exp_serr);
      end
      if (exp_pulses == 1) begin
        checks++;
        if (last_dv_cycle - st !== exp_lat) begin
          errors++;
          $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", n, last_dv_cycle - st, exp_lat);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] starting uart_rx_frame_ctrl bench");
    test_reset();
    test_good_no_parity();
    test_good_parity();
    test_parity_error();
    test_stop_error_and_glitch();
    test_noise_and_prescale5();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
